verinject_fault_scheduler: RTL and testbench
============================================

# verinject_fault_scheduler

Time-based sequencer for the fault-injection net. Software or a testbench loads a small queue of (cycle, bit index) fault entries. After `start`, the block counts clock cycles and drives `verinject__injector_state` with each entry's bit index for exactly one cycle when its target cycle is reached. Outside injection cycles it drives the idle value `32'hFFFF_FFFF`, which matches no injector. It sits at the top of an instrumented design and feeds the shared `verinject__injector_state` bus that every flip-flop injector decodes.

## Interface
Parameters:
- `DEPTH`, 4: fault queue entries; power of two, at least 2.
- `CYCLE_W`, 32: width of the cycle counter and of `cfg_cycle`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  pulse; begins a run from IDLE.
- `abort`  in  1  pulse; ends a run and flushes the queue.
- `cfg_valid`  in  1  a queue entry is offered.
- `cfg_ready`  out  1  the queue can accept an entry; equals !full.
- `cfg_cycle`  in  CYCLE_W  target cycle of the offered entry.
- `cfg_bit`  in  32  bit index to inject.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when a run ends normally.
- `missed`  out  1  sticky; an entry was injected later than its target.
- `inject_pulse`  out  1  high in every cycle a fault is driven.
- `verinject__injector_state`  out  32  fault select bus.

## Operation
- Queue:
  - FIFO with DEPTH entries, each holding {cycle, bit}.
  - Push on `cfg_valid && cfg_ready`, in any state, including during RUN.
  - Entries are expected in non-decreasing cycle order; the queue never reorders them.
- FSM states: IDLE and RUN.
  - IDLE → RUN on `start`. The cycle counter is cleared to 0 and `missed` is cleared.
  - In IDLE, the queue keeps its contents and the counter holds its value.
  - RUN → IDLE when the queue is empty at the clock edge, whether it just popped its last entry or was empty at `start`. `done` pulses for the first IDLE cycle.
  - RUN or IDLE → IDLE on `abort`. The queue is flushed, `done` is not pulsed, and the counter holds its value. `abort` has priority over `start`.
  - `start` during RUN is ignored.
- Counter:
  - Increments by 1 each RUN cycle.
  - Reads 0 in the first RUN cycle.
  - Saturates at all-ones; it does not wrap.
- Injection decision, made at each edge while in RUN:
  - If the queue is non-empty and head.cycle ≤ counter: register head.bit onto the output, pop the head, and assert `inject_pulse`.
  - If head.cycle < counter at that moment, set `missed`.
  - Otherwise register the idle value and deassert `inject_pulse`.
- At most one injection per cycle. When several entries share a cycle value, the second and later ones inject on consecutive cycles and set `missed`.
- A simultaneous push and pop is allowed when the queue is not full. Occupancy is unchanged.

## Timing
- Reset values:
  - State IDLE, queue empty, counter 0.
  - `verinject__injector_state` = 32'hFFFF_FFFF.
  - `inject_pulse`, `busy`, `done`, `missed` = 0.
  - `cfg_ready` = 1.
- Reset asserted mid-run forces all of the above immediately (asynchronous), including the idle value on the output bus.
- Outputs are registered:
  - An entry with cycle C drives its bit in the RUN cycle where the counter reads C+1.
  - The bus holds the bit for exactly one cycle and returns to idle the following cycle unless the next entry is also due.
- `busy` rises in the cycle after `start` is sampled.
- After `abort` is sampled, the output bus reads idle in the next cycle.
- `cfg_ready` reflects occupancy after the current edge. A push that fills the queue drops `cfg_ready` in the next cycle.

## Configuration
- `VERINJECT_SCHED_COUNT_EN`:
  - Defined: adds output `inject_count` (32 bits, reset 0). It increments on each injection, saturates at all-ones, and clears on `start`.
  - Undefined: the port and its counter are absent. All other behaviour is identical.

## Test plan
- Reset, then push {5, 17} and `start` → the bus reads 17 only in the cycle where the counter reads 6; `inject_pulse`=1 that cycle; `done` pulses once the queue is empty; `missed`=0.
- Push {3, 0}, {3, 1}, {10, 31} then `start` → the bus reads 0, 1, and 31 when the counter reads 4, 5, and 11 respectively; `missed`=1 after the second injection.
- Push 4 entries with DEPTH=4 → `cfg_ready`=0. Start, and when the first pop occurs `cfg_ready` returns to 1; a fifth entry pushed during RUN injects in order.
- `start` with an empty queue → `busy` is high for one cycle, `done` pulses, and the bus stays at FFFF_FFFF.
- Push {100, 9}, start, `abort` at counter 50 → IDLE next cycle, queue empty, no `done`, and the bus never shows 9. Also assert `rst` mid-run → all outputs reach reset values immediately.
- With `VERINJECT_SCHED_COUNT_EN` defined, inject 3 entries → `inject_count`=3; a new `start` clears it to 0.

Source files
------------

// File: rtl/verinject_fault_scheduler.sv
// Purpose : time-based sequencer driving the shared fault-select bus from a queue of {cycle, bit} entries.
// Latency : an entry with cycle C appears on verinject__injector_state when the run counter reads C+1, for one cycle.
// Backpr. : cfg_ready = !full (registered occupancy); entries offered while full are not taken.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   start, abort               run control pulses (abort wins, flushes the queue)
//   cfg_valid/cfg_ready        queue push handshake, payload cfg_cycle / cfg_bit
//   busy, done, missed         run status (missed is sticky until the next start)
//   inject_pulse               high in each cycle the bus carries a fault select
//   verinject__injector_state  fault select bus, 32'hFFFF_FFFF when idle
// Optional build macro VERINJECT_SCHED_COUNT_EN adds the inject_count output.
module verinject_fault_scheduler #(
  parameter int DEPTH   = 4,   // power of two, >= 2 (pointers wrap naturally)
  parameter int CYCLE_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CYCLE_W-1:0] cfg_cycle,
  input  logic [31:0]        cfg_bit,
  output logic               busy,
  output logic               done,
  output logic               missed,
  output logic               inject_pulse,
`ifdef VERINJECT_SCHED_COUNT_EN
  output logic [31:0]        inject_count,
`endif
  output logic [31:0]        verinject__injector_state
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [31:0] IDLE_SEL = 32'hFFFF_FFFF;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  typedef struct packed {
    logic [CYCLE_W-1:0] cycle;
    logic [31:0]        sel;
  } entry_t;

  state_t             state, state_nxt;
  entry_t             q_mem [DEPTH];
  entry_t             head;
  logic [AW-1:0]      rd_ptr, wr_ptr;
  logic [AW:0]        q_cnt;
  logic [CYCLE_W-1:0] cyc_cnt;
  logic               q_empty, q_full;
  logic               in_run, start_run, push, pop, late;

  assign q_empty   = (q_cnt == '0);
  assign q_full    = (q_cnt == FULL_CNT);
  assign cfg_ready = !q_full;
  assign head      = q_mem[rd_ptr];
  assign in_run    = (state == RUN);
  assign start_run = (state == IDLE) && start && !abort;

  // abort flushes, so a push in the same cycle is dropped rather than kept
  assign push = cfg_valid && !q_full && !abort;
  // head is due once the counter has reached its target; later pops are "late"
  assign pop  = in_run && !abort && !q_empty && (head.cycle <= cyc_cnt);
  assign late = (head.cycle < cyc_cnt);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!abort && start) state_nxt = RUN;
      // empty is evaluated before this edge's pop, so the last injection
      // still shows in a RUN cycle and the run ends one edge later
      RUN:     if (abort || q_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = 1'b0;
    if (state == RUN) busy = 1'b1;
  end

  // ---------------- queue storage (no reset needed) ----------------
  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= '{cycle: cfg_cycle, sel: cfg_bit};
  end

  // ---------------- queue pointers / occupancy ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      q_cnt  <= '0;
    end else if (abort) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      q_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   q_cnt <= q_cnt + CNT_ONE;
        2'b01:   q_cnt <= q_cnt - CNT_ONE;
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  // ---------------- run cycle counter (saturating) ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt <= '0;
    end else if (start_run) begin
      cyc_cnt <= '0;
    end else if (in_run && !abort && (cyc_cnt != {CYCLE_W{1'b1}})) begin
      cyc_cnt <= cyc_cnt + CYCLE_W'(1);
    end
  end

  // ---------------- registered outputs ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      verinject__injector_state <= IDLE_SEL;
      inject_pulse              <= 1'b0;
      done                      <= 1'b0;
      missed                    <= 1'b0;
    end else begin
      verinject__injector_state <= pop ? head.sel : IDLE_SEL;
      inject_pulse              <= pop;
      done                      <= in_run && q_empty && !abort;
      if (start_run)       missed <= 1'b0;
      else if (pop && late) missed <= 1'b1;
    end
  end

`ifdef VERINJECT_SCHED_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                inject_count <= '0;
    else if (start_run)                     inject_count <= '0;
    else if (pop && (inject_count != '1))   inject_count <= inject_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_verinject_fault_scheduler.sv
module tb_verinject_fault_scheduler;

  logic        clk = 1'b0;
  logic        rst, start, abort, cfg_valid, cfg_ready;
  logic        busy, done, missed, inject_pulse;
  logic [31:0] cfg_cycle, cfg_bit, bus;
`ifdef VERINJECT_SCHED_COUNT_EN
  logic [31:0] inject_count;
`endif

  always #5 clk = ~clk;

  verinject_fault_scheduler #(.DEPTH(4), .CYCLE_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_cycle(cfg_cycle),
    .cfg_bit(cfg_bit),
    .busy(busy),
    .done(done),
    .missed(missed),
    .inject_pulse(inject_pulse),
`ifdef VERINJECT_SCHED_COUNT_EN
    .inject_count(inject_count),
`endif
    .verinject__injector_state(bus)
  );

  // one entry: what is pushed, the counter reading at which its select must
  // appear on the bus, and the missed flag expected in that same cycle
  typedef struct {
    logic [31:0] cyc;
    logic [31:0] bitv;
    int          exp_idx;
    logic        exp_missed;
  } vec_t;

  vec_t tab [10];
  vec_t sb [$];
  int   n_vec = 0;
  int   n_err = 0;
  int   run_idx = 0;
  bit   prev_busy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: tracks the run counter independently (0 in first busy cycle)
  // and pops the scoreboard whenever the DUT shows an injection
  always @(negedge clk) begin : mon
    vec_t e;
    if (rst) begin
      prev_busy = 1'b0;
    end else begin
      if (busy) run_idx = prev_busy ? run_idx + 1 : 0;
      prev_busy = busy;
      if (inject_pulse) begin
        if (sb.size() == 0) begin
          check("unexpected_inject", {63'b0, inject_pulse}, 64'd0);
        end else begin
          e = sb.pop_front();
          check("inject_bit", {32'b0, bus}, {32'b0, e.bitv});
          check("inject_cycle", 64'(run_idx), 64'(e.exp_idx));
          check("missed_at_inject", {63'b0, missed}, {63'b0, e.exp_missed});
        end
      end else begin
        check("idle_bus", {32'b0, bus}, 64'h0000_0000_FFFF_FFFF);
      end
    end
  end

  // all tasks are entered just after a negedge and return just after one
  task automatic push_vec(input vec_t v);
    check("ready_before_push", {63'b0, cfg_ready}, 64'd1);
    cfg_valid = 1'b1;
    cfg_cycle = v.cyc;
    cfg_bit   = v.bitv;
    sb.push_back(v);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {63'b0, busy}, 64'd1);
  endtask

  task automatic wait_done(input int limit, input logic exp_missed);
    int k = 0;
    while (done !== 1'b1 && k < limit) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", {63'b0, done}, 64'd1);
    check("busy_at_done", {63'b0, busy}, 64'd0);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    check("missed_at_done", {63'b0, missed}, {63'b0, exp_missed});
    @(negedge clk);
    check("done_one_cycle", {63'b0, done}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_valid = 1'b0; cfg_cycle = '0; cfg_bit = '0;

    // single entry
    tab[0] = '{32'd5,   32'd17,  6,  1'b0};
    // shared cycle: second entry slips a cycle and is late
    tab[1] = '{32'd3,   32'd0,   4,  1'b0};
    tab[2] = '{32'd3,   32'd1,   5,  1'b1};
    tab[3] = '{32'd10,  32'd31,  11, 1'b1};
    // full queue, then a fifth entry during the run
    tab[4] = '{32'd2,   32'd100, 3,  1'b0};
    tab[5] = '{32'd4,   32'd101, 5,  1'b0};
    tab[6] = '{32'd6,   32'd102, 7,  1'b0};
    tab[7] = '{32'd8,   32'd103, 9,  1'b0};
    tab[8] = '{32'd20,  32'd104, 21, 1'b0};
    // far-future entry that abort must discard
    tab[9] = '{32'd100, 32'd9,   101, 1'b0};

    repeat (2) @(negedge clk);
    check("rst_bus",    {32'b0, bus}, 64'h0000_0000_FFFF_FFFF);
    check("rst_pulse",  {63'b0, inject_pulse}, 64'd0);
    check("rst_busy",   {63'b0, busy}, 64'd0);
    check("rst_done",   {63'b0, done}, 64'd0);
    check("rst_missed", {63'b0, missed}, 64'd0);
    check("rst_ready",  {63'b0, cfg_ready}, 64'd1);
    rst = 1'b0;
    @(negedge clk);

    // single entry
    push_vec(tab[0]);
    pulse_start();
    wait_done(40, 1'b0);

    // duplicate cycle values
    for (int i = 1; i <= 3; i++) push_vec(tab[i]);
    pulse_start();
    wait_done(40, 1'b1);
`ifdef VERINJECT_SCHED_COUNT_EN
    check("inject_count_3", {32'b0, inject_count}, 64'd3);
`endif

    // empty-queue start: one busy cycle then done
    pulse_start();
`ifdef VERINJECT_SCHED_COUNT_EN
    check("inject_count_cleared", {32'b0, inject_count}, 64'd0);
`endif
    @(negedge clk);
    check("empty_run_busy", {63'b0, busy}, 64'd0);
    check("empty_run_done", {63'b0, done}, 64'd1);
    check("empty_run_missed_cleared", {63'b0, missed}, 64'd0);
    @(negedge clk);
    check("empty_run_done_once", {63'b0, done}, 64'd0);

    // fill the queue, pop frees a slot, fifth entry pushed mid-run
    for (int i = 4; i <= 7; i++) push_vec(tab[i]);
    check("full_ready_low", {63'b0, cfg_ready}, 64'd0);
    pulse_start();
    k = 0;
    while (inject_pulse !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("first_pop_seen", {63'b0, inject_pulse}, 64'd1);
    check("ready_after_pop", {63'b0, cfg_ready}, 64'd1);
    push_vec(tab[8]);
    wait_done(60, 1'b0);

    // abort mid-run: no done, queue flushed, select 9 never appears
    push_vec(tab[9]);
    pulse_start();
    k = 0;
    while (run_idx < 50 && k < 100) begin
      @(negedge clk);
      k++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    sb.delete();
    check("abort_busy",  {63'b0, busy}, 64'd0);
    check("abort_done",  {63'b0, done}, 64'd0);
    check("abort_ready", {63'b0, cfg_ready}, 64'd1);
    check("abort_bus",   {32'b0, bus}, 64'h0000_0000_FFFF_FFFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", {63'b0, done}, 64'd0);
    end
    pulse_start();
    @(negedge clk);
    check("flushed_queue_done", {63'b0, done}, 64'd1);
    @(negedge clk);

    // asynchronous reset while a late injection is on the bus
    push_vec('{32'd3, 32'd5, 4, 1'b0});
    push_vec('{32'd3, 32'd6, 5, 1'b1});
    pulse_start();
    k = 0;
    while (!(inject_pulse === 1'b1 && missed === 1'b1) && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("late_inject_seen", {63'b0, missed}, 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_bus",    {32'b0, bus}, 64'h0000_0000_FFFF_FFFF);
    check("midrst_pulse",  {63'b0, inject_pulse}, 64'd0);
    check("midrst_busy",   {63'b0, busy}, 64'd0);
    check("midrst_done",   {63'b0, done}, 64'd0);
    check("midrst_missed", {63'b0, missed}, 64'd0);
    check("midrst_ready",  {63'b0, cfg_ready}, 64'd1);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
